// File: rtl/periodic_pattern_gen.sv
// periodic_pattern_gen: programmable square/sawtooth/pulse sample source with its own sample clock.
// Build macro PATTERN_NOISE_EN adds LFSR dither (-4..+3, saturating) to every sample.
//
// state | meaning
// IDLE  | waiting for start; config writable
// LOAD  | 16-cycle restoring division, step = floor(2A/P)
// RUN   | emitting one sample per sample_clk rise
// DRAIN | stop seen; finish current period, then IDLE
module periodic_pattern_gen #(
  parameter int DATA_WIDTH = 12,
  parameter int CLK_DIV    = 20,
  parameter int MIN_PERIOD = 20,
  parameter int MAX_PERIOD = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [15:0]                  cfg_period,
  input  logic [DATA_WIDTH-2:0]        cfg_amp,
  input  logic [1:0]                   cfg_shape,
  output logic                         cfg_err,
  input  logic                         start,
  input  logic                         stop,
  output logic                         sample_clk,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         en,
  output logic                         busy,
  output logic [15:0]                  period_ref
);
  localparam int AW = DATA_WIDTH + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);
  localparam logic [15:0] MAX_P = 16'(MAX_PERIOD);
  localparam logic signed [AW:0] SAT_MAX = (AW+1)'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [AW:0] SAT_MIN = (AW+1)'(-(2**(DATA_WIDTH-1)));

  logic [1:0]            state;
  logic [DW-1:0]         div_cnt;
  logic [15:0]           per_r;
  logic [DATA_WIDTH-2:0] amp_r;
  logic [1:0]            shape_r;
  logic [3:0]            load_cnt;
  logic [15:0]           div_rem, div_q;
  logic                  stop_pend, first;
  logic [15:0]           ph;
  logic signed [AW-1:0]  acc;

  logic                  rise, cfg_accept, cfg_legal;
  logic [15:0]           eff_per;
  logic [DATA_WIDTH-2:0] eff_amp;
  logic [16:0]           rem_sh;
  logic                  rem_ge;
  logic [15:0]           rem_nx;
  logic [15:0]           ph_nx;
  logic                  wrap;
  logic signed [AW-1:0]  amp_s, step_s, acc_nx, val;
  logic signed [AW:0]    noise, sum;
  logic signed [DATA_WIDTH-1:0] sample;

  assign rise       = (div_cnt == '0);
  assign cfg_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign period_ref = per_r;
  assign cfg_accept = cfg_valid && (state == S_IDLE);
  assign cfg_legal  = (cfg_period >= MIN_P) && (cfg_period <= MAX_P) && (cfg_shape != 2'd3);
  assign eff_per    = (cfg_accept && cfg_legal) ? cfg_period : per_r;
  assign eff_amp    = (cfg_accept && cfg_legal) ? cfg_amp : amp_r;

  // One restoring-division step per LOAD cycle; divisor is the already-committed period.
  assign rem_sh = {div_rem, div_q[15]};
  assign rem_ge = (rem_sh >= {1'b0, per_r});
  assign rem_nx = rem_ge ? 16'(rem_sh - {1'b0, per_r}) : rem_sh[15:0];

  assign ph_nx  = (first || (ph == per_r - 16'd1)) ? 16'd0 : ph + 16'd1;
  assign wrap   = (ph_nx == 16'd0);
  assign amp_s  = $signed({2'b00, amp_r});
  assign step_s = $signed(AW'(div_q));
  assign acc_nx = wrap ? -amp_s : acc + step_s;

  always_comb begin
    val = '0;
    case (shape_r)
      2'd0:    val = (ph_nx < {1'b0, per_r[15:1]}) ? amp_s : -amp_s;
      2'd1:    val = acc_nx;
      2'd2:    val = wrap ? amp_s : '0;
      default: val = '0;
    endcase
  end

`ifdef PATTERN_NOISE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else if (rise) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign noise = $signed({{(AW-2){1'b0}}, lfsr[2:0]}) - (AW+1)'(4);
`else
  assign noise = '0;
`endif

  always_comb begin
    sum = $signed({val[AW-1], val}) + noise;
    if (sum > SAT_MAX)      sample = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum < SAT_MIN) sample = SAT_MIN[DATA_WIDTH-1:0];
    else                    sample = sum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      sample_clk <= 1'b0;
      data_out   <= '0;
      en         <= 1'b0;
      cfg_err    <= 1'b0;
      per_r      <= 16'd64;
      amp_r      <= (DATA_WIDTH-1)'(1000);
      shape_r    <= 2'd0;
      load_cnt   <= '0;
      div_rem    <= '0;
      div_q      <= '0;
      stop_pend  <= 1'b0;
      first      <= 1'b0;
      ph         <= '0;
      acc        <= '0;
    end else begin
      cfg_err <= 1'b0;
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      if (rise) sample_clk <= 1'b1;
      else if (div_cnt == DIV_HALF) sample_clk <= 1'b0;

      if (cfg_accept) begin
        if (cfg_legal) begin
          per_r   <= cfg_period;
          amp_r   <= cfg_amp;
          shape_r <= cfg_shape;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start && !(cfg_accept && !cfg_legal)) begin
            state     <= S_LOAD;
            load_cnt  <= '0;
            div_rem   <= '0;
            div_q     <= 16'({eff_amp, 1'b0});
            stop_pend <= 1'b0;
          end
        end
        S_LOAD: begin
          div_rem  <= rem_nx;
          div_q    <= {div_q[14:0], rem_ge};
          load_cnt <= load_cnt + 4'd1;
          if (stop) stop_pend <= 1'b1;
          if (load_cnt == 4'd15) begin
            state <= (stop_pend || stop) ? S_IDLE : S_RUN;
            first <= 1'b1;
          end
        end
        S_RUN, S_DRAIN: begin
          if (state == S_RUN && stop) state <= S_DRAIN;
          if (rise) begin
            first <= 1'b0;
            if (state == S_DRAIN && wrap) begin
              data_out <= '0;
              en       <= 1'b0;
              state    <= S_IDLE;
            end else begin
              ph       <= ph_nx;
              acc      <= acc_nx;
              data_out <= sample;
              en       <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_periodic_pattern_gen.sv
// Directed bench for periodic_pattern_gen: reset/idle, square, sawtooth, pulse, config rejection,
// stop/drain, stop during LOAD and reset mid-run, with hand-computed expected samples.
module tb_periodic_pattern_gen;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [15:0]       cfg_period = 16'd0;
  logic [10:0]       cfg_amp = 11'd0;
  logic [1:0]        cfg_shape = 2'd0;
  logic              cfg_err;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              sample_clk;
  logic signed [11:0] data_out;
  logic              en;
  logic              busy;
  logic [15:0]       period_ref;

  int checks = 0;
  int errors = 0;

  periodic_pattern_gen dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_amp(cfg_amp), .cfg_shape(cfg_shape), .cfg_err(cfg_err),
    .start(start), .stop(stop), .sample_clk(sample_clk), .data_out(data_out), .en(en),
    .busy(busy), .period_ref(period_ref)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the first falling clk edge after sample_clk goes high.
  task automatic wait_rise();
    logic p;
    bit   got;
    p = sample_clk;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (sample_clk && !p) got = 1'b1;
      p = sample_clk;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL rise_timeout: observed no sample_clk rise, expected one within 40 cycles");
    end
  endtask

  task automatic offer(input int p, input int a, input int s, input int exp_err, input int exp_ref);
    cfg_valid = 1'b1; cfg_period = 16'(p); cfg_amp = 11'(a); cfg_shape = 2'(s);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_err_pulse", cfg_err, exp_err);
    chk("cfg_period_ref", period_ref, exp_ref);
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, cfg_ready, 1);
  endtask

  initial begin
    int per, hi;
    logic p;

    // 1: reset state and idle sample clock
    repeat (3) @(negedge clk);
    chk("rst_sclk", sample_clk, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_ref", period_ref, 64);
    chk_idle("rst");
    rst = 1'b0;
    wait_rise();
    per = 0; hi = 1; p = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      per++;
      if (sample_clk && !p) break;
      if (sample_clk) hi++;
      p = sample_clk;
    end
    chk("sclk_period", per, 20);
    chk("sclk_high", hi, 10);
    repeat (100) @(negedge clk);
    chk_idle("idle100");
    chk("idle100_ref", period_ref, 64);

    // 2: square P=100 A=1000; start lands so a rise hits the last LOAD cycle
    offer(100, 1000, 0, 0, 100);
    wait_rise();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_ready", cfg_ready, 0);
    cfg_valid = 1'b1; cfg_period = 16'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("busy_cfg_ignored_err", cfg_err, 0);
    chk("busy_cfg_ignored_ref", period_ref, 100);
    wait_rise();
    chk("load_last_no_sample", en, 0);
    for (int i = 0; i <= 130; i++) begin
      wait_rise();
      chk("sq_en", en, 1);
      chk("sq_data", data_out, ((i % 100) < 50) ? 1000 : -1000);
    end

    // 5: stop after ph=30, remainder of period then drain
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int ph = 31; ph <= 99; ph++) begin
      wait_rise();
      chk("drain_en", en, 1);
      chk("drain_data", data_out, (ph < 50) ? 1000 : -1000);
    end
    wait_rise();
    chk_idle("drain_end");

    // 4: rejected and boundary configs
    offer(5, 1000, 0, 1, 100);
    offer(600, 1000, 0, 1, 100);
    offer(50, 1000, 3, 1, 100);
    offer(19, 1000, 0, 1, 100);
    offer(513, 1000, 0, 1, 100);
    offer(20, 1000, 1, 0, 20);
    offer(512, 1000, 2, 0, 512);
    cfg_valid = 1'b1; cfg_period = 16'd5; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    chk("bad_start_err", cfg_err, 1);
    chk("bad_start_busy", busy, 0);
    chk("bad_start_ref", period_ref, 512);
    @(negedge clk);
    chk("bad_start_busy2", busy, 0);

    // 3: sawtooth P=64 A=1024 offered together with start; first sample on next rise
    wait_rise();
    repeat (2) @(negedge clk);
    cfg_valid = 1'b1; cfg_period = 16'd64; cfg_amp = 11'd1024; cfg_shape = 2'd1; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    chk("saw_ref", period_ref, 64);
    chk("saw_busy", busy, 1);
    chk("saw_err", cfg_err, 0);
    for (int i = 0; i <= 64; i++) begin
      wait_rise();
      chk("saw_en", en, 1);
      chk("saw_data", data_out, -1024 + 32 * (i % 64));
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int ph = 1; ph <= 63; ph++) begin
      wait_rise();
      chk("saw_drain_data", data_out, -1024 + 32 * ph);
    end
    wait_rise();
    chk_idle("saw_drain_end");

    // stop during LOAD: back to IDLE, no samples
    offer(40, 500, 2, 0, 40);
    wait_rise();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (20) @(negedge clk);
    chk_idle("load_stop");

    // pulse P=40 A=500
    wait_rise();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 40; i++) begin
      wait_rise();
      chk("pulse_en", en, 1);
      chk("pulse_data", data_out, ((i % 40) == 0) ? 500 : 0);
    end

    // 6: one-cycle reset mid-run, right after a +500 sample with sample_clk high
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sclk", sample_clk, 0);
    chk("midrst_err", cfg_err, 0);
    chk("midrst_ref", period_ref, 64);
    chk_idle("midrst");
    wait_rise();
    chk_idle("midrst_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
